// File: rtl/dis_nport_variable.sv
// dis_nport_variable: store-and-forward packet distributor.
// Framed variable-length packets are buffered whole in an internal FIFO and replayed to the
// subset of output ports selected by the header bitmap. Packets that cannot be guaranteed room
// are dropped whole on arrival; overlong packets are cut at MAX_PKT_WORDS.
// Optional feature: define DIS_MAC_PREFIX_EN to prepend a two-word MAC prefix (MAC_H, MAC_L)
// derived from the destination IP. Without it the IP word itself leads the output frame.
module dis_nport_variable #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned ADDR_W        = 9,
    parameter int unsigned MAX_PKT_WORDS = 64,
    parameter logic [15:0] OUI_HI        = 16'h0012,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_en,
    output logic [DATA_W-1:0]    dout,
    output logic [NUM_PORTS-1:0] dout_port_en,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     pkt_cnt_out,
    output logic                 err_trunc
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    // FIFO entry layout: {sop, eop, data}
    localparam int unsigned ENT_W = DATA_W + 2;
    localparam logic [ADDR_W:0] DEPTH_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MAX_WORDS   = (ADDR_W+1)'(MAX_PKT_WORDS);

    // Write-side states
    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_PKT     = 2'd1;
    localparam logic [1:0] W_DISCARD = 2'd2;

    // Read-side states
    localparam logic [2:0] R_IDLE = 3'd0;
    localparam logic [2:0] R_HDR  = 3'd1;
    localparam logic [2:0] R_IP   = 3'd2;
`ifdef DIS_MAC_PREFIX_EN
    localparam logic [2:0] R_MACH = 3'd3;
    localparam logic [2:0] R_MACL = 3'd4;
`endif
    localparam logic [2:0] R_DATA = 3'd5;
    localparam logic [2:0] R_DROP = 3'd6;
    localparam logic [2:0] R_GAP  = 3'd7;

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   fill, free_words;
    logic              wr_en, rd_en;
    logic [ENT_W-1:0]  wr_ent;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_eop_q;
    // Number of complete packets sitting in the FIFO
    logic [ADDR_W:0]   pkts_q;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign free_words = DEPTH_WORDS - fill;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [1:0]        w_state_q, w_state_d;
    logic              din_en_q;
    logic              din_rise;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              tail_sop_q, tail_sop_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              wr_eop;
    logic              wr_drop;
    logic              trunc_d;

    assign din_rise = din_en & ~din_en_q;
    assign wr_ent   = {tail_sop_q, wr_eop, tail_q};

    // Write FSM next state: admission check, tail-register staging and truncation
    always_comb begin
        w_state_d  = w_state_q;
        tail_d     = tail_q;
        tail_sop_d = tail_sop_q;
        wcnt_d     = wcnt_q;
        wr_en      = 1'b0;
        wr_eop     = 1'b0;
        wr_drop    = 1'b0;
        trunc_d    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (din_rise) begin
                    // Admit only if the largest possible packet is guaranteed to fit
                    if (free_words >= MAX_WORDS) begin
                        w_state_d  = W_PKT;
                        tail_d     = din;
                        tail_sop_d = 1'b1;
                        wcnt_d     = {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        w_state_d = W_DISCARD;
                        wr_drop   = 1'b1;
                    end
                end
            end
            W_PKT: begin
                wr_en = 1'b1;
                if (!din_en) begin
                    // End of packet: flush the held word as the last one
                    wr_eop    = 1'b1;
                    w_state_d = W_IDLE;
                end else if (wcnt_q == MAX_WORDS) begin
                    // A word beyond the limit arrived: close the packet on the held word
                    wr_eop    = 1'b1;
                    trunc_d   = 1'b1;
                    w_state_d = W_DISCARD;
                end else begin
                    tail_d     = din;
                    tail_sop_d = 1'b0;
                    wcnt_d     = wcnt_q + 1'b1;
                end
            end
            W_DISCARD: begin
                if (!din_en) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state and staging registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            // Treat din_en as already high so a packet in flight at release is not admitted
            din_en_q   <= 1'b1;
            tail_q     <= '0;
            tail_sop_q <= 1'b0;
            wcnt_q     <= '0;
            err_trunc  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            din_en_q   <= din_en;
            tail_q     <= tail_d;
            tail_sop_q <= tail_sop_d;
            wcnt_q     <= wcnt_d;
            err_trunc  <= trunc_d;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [2:0]           r_state_q, r_state_d;
    logic [NUM_PORTS-1:0] bitmap_q, bitmap_d;
    logic                 emit;
    logic [DATA_W-1:0]    emit_data;
    logic                 rd_pkt_done;
    logic                 rd_drop;
    logic                 frame_done;
`ifdef DIS_MAC_PREFIX_EN
    logic [31:0]          ip_q, ip_d;
    logic                 ip_eop_q, ip_eop_d;
`else
    logic                 unused_oui_hi;
    assign unused_oui_hi = ^OUI_HI;
`endif

    // Read FSM next state: header decode, prefix generation, payload replay and drop
    always_comb begin
        r_state_d   = r_state_q;
        bitmap_d    = bitmap_q;
        rd_en       = 1'b0;
        emit        = 1'b0;
        emit_data   = '0;
        rd_pkt_done = 1'b0;
        rd_drop     = 1'b0;
        frame_done  = 1'b0;
`ifdef DIS_MAC_PREFIX_EN
        ip_d        = ip_q;
        ip_eop_d    = ip_eop_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                // Prefetch the header so it is on rd_data_q while in R_HDR
                if (pkts_q != '0) begin
                    rd_en     = 1'b1;
                    r_state_d = R_HDR;
                end
            end
            R_HDR: begin
                bitmap_d = rd_data_q[NUM_PORTS-1:0];
                if (rd_eop_q) begin
                    rd_drop     = 1'b1;
                    rd_pkt_done = 1'b1;
                    r_state_d   = R_GAP;
                end else begin
                    rd_en = 1'b1;
                    if (rd_data_q[NUM_PORTS-1:0] == '0) begin
                        rd_drop   = 1'b1;
                        r_state_d = R_DROP;
                    end else begin
                        r_state_d = R_IP;
                    end
                end
            end
            R_IP: begin
`ifdef DIS_MAC_PREFIX_EN
                ip_d     = rd_data_q[31:0];
                ip_eop_d = rd_eop_q;
                if (rd_eop_q) begin
                    rd_pkt_done = 1'b1;
                end else begin
                    // First payload word is fetched now and held through the MAC words
                    rd_en = 1'b1;
                end
                r_state_d = R_MACH;
`else
                emit      = 1'b1;
                emit_data = rd_data_q;
                if (rd_eop_q) begin
                    rd_pkt_done = 1'b1;
                    frame_done  = 1'b1;
                    r_state_d   = R_GAP;
                end else begin
                    rd_en     = 1'b1;
                    r_state_d = R_DATA;
                end
`endif
            end
`ifdef DIS_MAC_PREFIX_EN
            R_MACH: begin
                emit            = 1'b1;
                emit_data[31:0] = {OUI_HI, ip_q[31:16]};
                r_state_d       = R_MACL;
            end
            R_MACL: begin
                emit            = 1'b1;
                emit_data[31:0] = {16'h0000, ip_q[15:0]};
                if (ip_eop_q) begin
                    frame_done = 1'b1;
                    r_state_d  = R_GAP;
                end else begin
                    r_state_d = R_DATA;
                end
            end
`endif
            R_DATA: begin
                emit      = 1'b1;
                emit_data = rd_data_q;
                if (rd_eop_q) begin
                    rd_pkt_done = 1'b1;
                    frame_done  = 1'b1;
                    r_state_d   = R_GAP;
                end else begin
                    rd_en = 1'b1;
                end
            end
            R_DROP: begin
                if (rd_eop_q) begin
                    rd_pkt_done = 1'b1;
                    r_state_d   = R_GAP;
                end else begin
                    rd_en = 1'b1;
                end
            end
            R_GAP: r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and latched header fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            bitmap_q  <= '0;
`ifdef DIS_MAC_PREFIX_EN
            ip_q      <= '0;
            ip_eop_q  <= 1'b0;
`endif
        end else begin
            r_state_q <= r_state_d;
            bitmap_q  <= bitmap_d;
`ifdef DIS_MAC_PREFIX_EN
            ip_q      <= ip_d;
            ip_eop_q  <= ip_eop_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, registered read port and committed-packet count
    // ------------------------------------------------------------------

    // Memory array write port (no reset on storage)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_ent;
        end
    end

    // Pointers, registered read data and committed-packet bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
            rd_eop_q  <= 1'b0;
            pkts_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]][DATA_W-1:0];
                rd_eop_q  <= mem[rd_ptr_q[ADDR_W-1:0]][DATA_W];
            end
            case ({wr_en & wr_eop, rd_pkt_done})
                2'b10:   pkts_q <= pkts_q + 1'b1;
                2'b01:   pkts_q <= pkts_q - 1'b1;
                default: pkts_q <= pkts_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs and statistics
    // ------------------------------------------------------------------
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W:0]   pkt_sum;
    logic [CNT_W-1:0] drop_d, pkt_d;

    // Saturating counter updates; both FSMs may drop in the same cycle
    always_comb begin
        drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(wr_drop) + (CNT_W+1)'(rd_drop);
        pkt_sum  = {1'b0, pkt_cnt_out} + (CNT_W+1)'(frame_done);
        drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        pkt_d    = pkt_sum[CNT_W] ? {CNT_W{1'b1}} : pkt_sum[CNT_W-1:0];
    end

    // Registered frame outputs and counters; dout is forced to zero between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout         <= '0;
            dout_port_en <= '0;
            drop_cnt     <= '0;
            pkt_cnt_out  <= '0;
        end else begin
            dout         <= emit ? emit_data : '0;
            dout_port_en <= emit ? bitmap_q : '0;
            drop_cnt     <= drop_d;
            pkt_cnt_out  <= pkt_d;
        end
    end

endmodule

// File: tb/tb_dis_nport_variable.sv
// Directed bench for dis_nport_variable. A default-sized instance covers unicast, multicast,
// drop, degenerate lengths, truncation and reset; a small-FIFO instance covers admission drop.
// Expectations follow DIS_MAC_PREFIX_EN when it is defined for the build.
module tb_dis_nport_variable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] din_a, din_b;
    logic        din_en_a, din_en_b;
    logic [31:0] dout_a, dout_b;
    logic [3:0]  en_a, en_b;
    logic [15:0] drop_a, drop_b, pkt_a, pkt_b;
    logic        err_a, err_b;

    dis_nport_variable u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din_a),
        .din_en       (din_en_a),
        .dout         (dout_a),
        .dout_port_en (en_a),
        .drop_cnt     (drop_a),
        .pkt_cnt_out  (pkt_a),
        .err_trunc    (err_a)
    );

    // 16-word FIFO, 15-word limit: a packet is admitted only when at most one word is queued
    dis_nport_variable #(
        .ADDR_W        (4),
        .MAX_PKT_WORDS (15)
    ) u_dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din_b),
        .din_en       (din_en_b),
        .dout         (dout_b),
        .dout_port_en (en_b),
        .drop_cnt     (drop_b),
        .pkt_cnt_out  (pkt_b),
        .err_trunc    (err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Frame capture
    logic [31:0] cap_a_d[$], cap_b_d[$];
    logic [3:0]  cap_a_e[$], cap_b_e[$];
    int          idle_nz_a = 0, idle_nz_b = 0, trunc_a = 0;

    always @(negedge clk) begin
        if (en_a != 4'd0) begin
            cap_a_d.push_back(dout_a);
            cap_a_e.push_back(en_a);
        end else if (dout_a != 32'd0) begin
            idle_nz_a++;
        end
        if (en_b != 4'd0) begin
            cap_b_d.push_back(dout_b);
            cap_b_e.push_back(en_b);
        end else if (dout_b != 32'd0) begin
            idle_nz_b++;
        end
        if (err_a) trunc_a++;
    end

    logic [31:0] pkt [128];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_e[$];

    task automatic make_pkt(input logic [31:0] bitmap, input logic [31:0] ip, input int n,
                            input logic [31:0] base);
        pkt[0] = bitmap;
        pkt[1] = ip;
        for (int i = 2; i < n; i++) pkt[i] = base + 32'(i - 2);
    endtask

    task automatic exp_clear();
        exp_d.delete();
        exp_e.delete();
    endtask

    // Append the expected frame for the first n stored words of pkt[]
    task automatic build_exp(input int n, input logic [3:0] en);
        logic [31:0] ip;
        ip = pkt[1];
`ifdef DIS_MAC_PREFIX_EN
        exp_d.push_back({16'h0012, ip[31:16]});
        exp_e.push_back(en);
        exp_d.push_back({16'h0000, ip[15:0]});
        exp_e.push_back(en);
`else
        exp_d.push_back(ip);
        exp_e.push_back(en);
`endif
        for (int i = 2; i < n; i++) begin
            exp_d.push_back(pkt[i]);
            exp_e.push_back(en);
        end
    endtask

    task automatic send(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (which == 0) begin
                din_a    = pkt[i];
                din_en_a = 1'b1;
            end else begin
                din_b    = pkt[i];
                din_en_b = 1'b1;
            end
        end
        @(negedge clk);
        din_a    = '0;
        din_en_a = 1'b0;
        din_b    = '0;
        din_en_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare captured words against exp_d/exp_e, then clear the capture
    task automatic check_frame(input string tag, input int which);
        logic [31:0] got_d[$];
        logic [3:0]  got_e[$];
        if (which == 0) begin
            got_d = cap_a_d;
            got_e = cap_a_e;
        end else begin
            got_d = cap_b_d;
            got_e = cap_b_e;
        end
        check_eq($sformatf("%s_len", tag), 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check_eq($sformatf("%s_d%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
            check_eq($sformatf("%s_en%0d", tag, i), 64'(got_e[i]), 64'(exp_e[i]));
        end
        cap_a_d.delete();
        cap_a_e.delete();
        cap_b_d.delete();
        cap_b_e.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic started;
        rst_n    = 1'b0;
        din_a    = '0;
        din_b    = '0;
        din_en_a = 1'b0;
        din_en_b = 1'b0;
        idle(3);
        check_eq("rst_dout", 64'(dout_a), 64'd0);
        check_eq("rst_en", 64'(en_a), 64'd0);
        check_eq("rst_drop", 64'(drop_a), 64'd0);
        check_eq("rst_pkt", 64'(pkt_a), 64'd0);
        check_eq("rst_err", 64'(err_a), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Unicast
        make_pkt(32'h1, 32'hC0A80105, 6, 32'hD000_0000);
        exp_clear();
        build_exp(6, 4'b0001);
        send(0, 6);
        idle(30);
        check_frame("uni", 0);
        check_eq("uni_pkt", 64'(pkt_a), 64'd1);
        check_eq("uni_drop", 64'(drop_a), 64'd0);

        // Multicast to ports 0 and 3
        make_pkt(32'h9, 32'h0A000001, 4, 32'hE000_0000);
        exp_clear();
        build_exp(4, 4'b1001);
        send(0, 4);
        idle(30);
        check_frame("mc", 0);
        check_eq("mc_pkt", 64'(pkt_a), 64'd2);

        // Bitmap selects only nonexistent ports
        make_pkt(32'h30, 32'h0A000002, 3, 32'hE100_0000);
        exp_clear();
        send(0, 3);
        idle(30);
        check_frame("bm30", 0);
        check_eq("bm30_drop", 64'(drop_a), 64'd1);
        check_eq("bm30_pkt", 64'(pkt_a), 64'd2);

        // Header-only packet
        make_pkt(32'h1, 32'h0, 1, 32'h0);
        exp_clear();
        send(0, 1);
        idle(30);
        check_frame("hdr", 0);
        check_eq("hdr_drop", 64'(drop_a), 64'd2);

        // Header + IP only
        make_pkt(32'h2, 32'hC0A80202, 2, 32'h0);
        exp_clear();
        build_exp(2, 4'b0010);
        send(0, 2);
        idle(30);
        check_frame("hip", 0);
        check_eq("hip_pkt", 64'(pkt_a), 64'd3);

        // 70-word packet is cut to the first 64 words
        make_pkt(32'h4, 32'h0B0B0B0B, 70, 32'hF000_0000);
        exp_clear();
        build_exp(64, 4'b0100);
        send(0, 70);
        idle(100);
        check_frame("trunc", 0);
        check_eq("trunc_pulses", 64'(trunc_a), 64'd1);
        check_eq("trunc_pkt", 64'(pkt_a), 64'd4);
        check_eq("trunc_drop", 64'(drop_a), 64'd2);

        make_pkt(32'h1, 32'h0C0C0C0C, 3, 32'hA500_0000);
        exp_clear();
        build_exp(3, 4'b0001);
        send(0, 3);
        idle(30);
        check_frame("post_trunc", 0);
        check_eq("post_trunc_pkt", 64'(pkt_a), 64'd5);
        check_eq("post_trunc_pulses", 64'(trunc_a), 64'd1);

        // Reset in the middle of an output frame
        make_pkt(32'h8, 32'h0D0D0D0D, 24, 32'hB000_0000);
        send(0, 24);
        started = 1'b0;
        for (int k = 0; k < 100 && !started; k++) begin
            @(negedge clk);
            if (en_a != 4'd0) started = 1'b1;
        end
        check_eq("rst_frame_started", 64'(started), 64'd1);
        idle(3);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dout", 64'(dout_a), 64'd0);
        check_eq("midrst_en", 64'(en_a), 64'd0);
        check_eq("midrst_drop", 64'(drop_a), 64'd0);
        check_eq("midrst_pkt", 64'(pkt_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cap_a_d.delete();
        cap_a_e.delete();
        exp_clear();
        idle(40);
        check_frame("rst_nofr", 0);

        make_pkt(32'h1, 32'hC0A80105, 6, 32'hD000_0000);
        exp_clear();
        build_exp(6, 4'b0001);
        send(0, 6);
        idle(30);
        check_frame("after_rst", 0);
        check_eq("after_rst_pkt", 64'(pkt_a), 64'd1);

        // Small FIFO: second back-to-back packet finds free=12 < 15 and is dropped whole
        make_pkt(32'h1, 32'h01020304, 4, 32'hAA00_0000);
        exp_clear();
        build_exp(4, 4'b0001);
        send(1, 4);
        make_pkt(32'h2, 32'h05060708, 4, 32'hBB00_0000);
        send(1, 4);
        idle(40);
        make_pkt(32'h4, 32'h090A0B0C, 3, 32'hCC00_0000);
        build_exp(3, 4'b0100);
        send(1, 3);
        idle(40);
        check_frame("ovf", 1);
        check_eq("ovf_drop", 64'(drop_b), 64'd1);
        check_eq("ovf_pkt", 64'(pkt_b), 64'd2);

        check_eq("idle_zero_a", 64'(idle_nz_a), 64'd0);
        check_eq("idle_zero_b", 64'(idle_nz_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
